// File: rtl/rf_rename_mp_if.sv
// Bus bundle for rf_rename_mp: decode-side lookup/rename, ROB commit and
// fetch-side JALR base lookup. Per-slot/per-port fields are packed with
// slot i at [i*W +: W].
//   master : dispatch/commit side (drives requests, receives lookup results)
//   slave  : the register file
interface rf_rename_mp_if #(
    parameter int XLEN     = 32,
    parameter int REG_W    = 5,
    parameter int TAG_W    = 5,
    parameter int ISSUE_W  = 2,
    parameter int COMMIT_W = 2
);
    logic                        rdy_in;
    logic                        flush_in;

    logic [COMMIT_W-1:0]         cm_valid;
    logic [COMMIT_W*REG_W-1:0]   cm_rd;
    logic [COMMIT_W*XLEN-1:0]    cm_value;
    logic [COMMIT_W*TAG_W-1:0]   cm_tag;

    logic [ISSUE_W-1:0]          is_valid;
    logic [ISSUE_W*REG_W-1:0]    is_rd;
    logic [ISSUE_W*TAG_W-1:0]    is_tag;

    logic [ISSUE_W*REG_W-1:0]    rs1_idx;
    logic [ISSUE_W*REG_W-1:0]    rs2_idx;
    logic [ISSUE_W*XLEN-1:0]     rs1_value;
    logic [ISSUE_W-1:0]          rs1_busy;
    logic [ISSUE_W*TAG_W-1:0]    rs1_tag;
    logic [ISSUE_W*XLEN-1:0]     rs2_value;
    logic [ISSUE_W-1:0]          rs2_busy;
    logic [ISSUE_W*TAG_W-1:0]    rs2_tag;

    logic [REG_W-1:0]            jr_idx;
    logic [XLEN-1:0]             jr_value;
    logic                        jr_busy;

    modport master (
        output rdy_in, flush_in,
        output cm_valid, cm_rd, cm_value, cm_tag,
        output is_valid, is_rd, is_tag,
        output rs1_idx, rs2_idx, jr_idx,
        input  rs1_value, rs1_busy, rs1_tag,
        input  rs2_value, rs2_busy, rs2_tag,
        input  jr_value, jr_busy
    );

    modport slave (
        input  rdy_in, flush_in,
        input  cm_valid, cm_rd, cm_value, cm_tag,
        input  is_valid, is_rd, is_tag,
        input  rs1_idx, rs2_idx, jr_idx,
        output rs1_value, rs1_busy, rs1_tag,
        output rs2_value, rs2_busy, rs2_tag,
        output jr_value, jr_busy
    );
endinterface

// File: rtl/rf_rename_mp.sv
// Architectural register file with per-register rename status (busy + ROB
// tag) for ISSUE_W decode slots and COMMIT_W commit ports per cycle.
// Source lookups are combinational and see same-cycle commits plus renames
// from older slots of the same bundle.
// Ports:
//   clk_in : clock, all state changes on the rising edge
//   rst_in : synchronous active-high reset
//   bus    : rf_rename_mp_if.slave (enable, flush, commit, rename, lookups)
module rf_rename_mp #(
    parameter int XLEN     = 32,
    parameter int REG_W    = 5,
    parameter int TAG_W    = 5,
    parameter int ISSUE_W  = 2,
    parameter int COMMIT_W = 2
) (
    input  logic          clk_in,
    input  logic          rst_in,
    rf_rename_mp_if.slave bus
);
    localparam int NUM_REGS = 2 ** REG_W;

    // Architectural state. Kept in flops: every slot reads two sources plus
    // the JALR port combinationally in the same cycle.
    logic [XLEN-1:0]     regs_reg  [NUM_REGS];
    logic [XLEN-1:0]     regs_next [NUM_REGS];
    logic [TAG_W-1:0]    tag_reg   [NUM_REGS];
    logic [TAG_W-1:0]    tag_next  [NUM_REGS];
    logic [NUM_REGS-1:0] busy_reg;
    logic [NUM_REGS-1:0] busy_next;

    // Per-port views of the packed buses
    logic [COMMIT_W-1:0]             cm_valid;
    logic [COMMIT_W-1:0][REG_W-1:0]  cm_rd;
    logic [COMMIT_W-1:0][XLEN-1:0]   cm_value;
    logic [COMMIT_W-1:0][TAG_W-1:0]  cm_tag;
    logic [ISSUE_W-1:0]              is_valid;
    logic [ISSUE_W-1:0][REG_W-1:0]   is_rd;
    logic [ISSUE_W-1:0][TAG_W-1:0]   is_tag;
    logic [1:0][ISSUE_W-1:0][REG_W-1:0] src_idx;   // [source][slot]
    logic [1:0][ISSUE_W-1:0][XLEN-1:0]  src_value;
    logic [1:0][ISSUE_W-1:0]            src_busy;
    logic [1:0][ISSUE_W-1:0][TAG_W-1:0] src_tag;

    assign cm_valid   = bus.cm_valid;
    assign cm_rd      = bus.cm_rd;
    assign cm_value   = bus.cm_value;
    assign cm_tag     = bus.cm_tag;
    assign is_valid   = bus.is_valid;
    assign is_rd      = bus.is_rd;
    assign is_tag     = bus.is_tag;
    assign src_idx[0] = bus.rs1_idx;
    assign src_idx[1] = bus.rs2_idx;

    assign bus.rs1_value = src_value[0];
    assign bus.rs1_busy  = src_busy[0];
    assign bus.rs1_tag   = src_tag[0];
    assign bus.rs2_value = src_value[1];
    assign bus.rs2_busy  = src_busy[1];
    assign bus.rs2_tag   = src_tag[1];

    // JALR base: committed state only, no forwarding
    assign bus.jr_value = regs_reg[bus.jr_idx];
    assign bus.jr_busy  = busy_reg[bus.jr_idx];

    // ------------------------------------------------------------------
    // Source lookup. Later assignments override earlier ones, so the
    // statements run from lowest to highest priority.
    // ------------------------------------------------------------------
    genvar gi, gs;
    generate
        for (gi = 0; gi < ISSUE_W; gi++) begin : g_slot
            for (gs = 0; gs < 2; gs++) begin : g_src
                logic [REG_W-1:0] idx;
                logic [XLEN-1:0]  val_c;
                logic             busy_c;
                logic [TAG_W-1:0] tag_c;

                assign idx = src_idx[gs][gi];

                always_comb begin
                    // Committed state, value bypassed from the youngest
                    // commit port writing this register.
                    val_c  = regs_reg[idx];
                    busy_c = busy_reg[idx];
                    tag_c  = tag_reg[idx];
                    for (int p = 0; p < COMMIT_W; p++) begin
                        if (cm_valid[p] && cm_rd[p] == idx) begin
                            val_c = cm_value[p];
                        end
                    end
                    // The producer we would wait on is committing right now.
                    if (busy_reg[idx]) begin
                        for (int p = 0; p < COMMIT_W; p++) begin
                            if (cm_valid[p] && cm_tag[p] == tag_reg[idx]) begin
                                busy_c = 1'b0;
                                val_c  = cm_value[p];
                            end
                        end
                    end
                    // Youngest older slot of this bundle renaming the source;
                    // the slot's own destination is deliberately excluded.
                    for (int j = 0; j < gi; j++) begin
                        if (is_valid[j] && is_rd[j] == idx) begin
                            busy_c = 1'b1;
                            tag_c  = is_tag[j];
                        end
                    end
                    // x0 reads as a ready zero regardless of anything else
                    if (idx == '0) begin
                        val_c  = '0;
                        busy_c = 1'b0;
                        tag_c  = '0;
                    end
                end

                assign src_value[gs][gi] = val_c;
                assign src_busy[gs][gi]  = busy_c;
                assign src_tag[gs][gi]   = tag_c;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next state. Commits go first so a same-cycle rename of the same
    // register wins over the commit's busy clear.
    // ------------------------------------------------------------------
    always_comb begin
        regs_next = regs_reg;
        busy_next = busy_reg;
        tag_next  = tag_reg;
        for (int p = 0; p < COMMIT_W; p++) begin
            if (cm_valid[p] && cm_rd[p] != '0) begin
                regs_next[cm_rd[p]] = cm_value[p];
                // Only the producer currently named by the tag releases it;
                // an older (stale) commit leaves the newer rename in place.
                if (busy_reg[cm_rd[p]] && tag_reg[cm_rd[p]] == cm_tag[p]) begin
                    busy_next[cm_rd[p]] = 1'b0;
                end
            end
        end
        if (bus.flush_in) begin
            busy_next = '0;
        end else begin
            for (int s = 0; s < ISSUE_W; s++) begin
                if (is_valid[s] && is_rd[s] != '0) begin
                    busy_next[is_rd[s]] = 1'b1;
                    tag_next[is_rd[s]]  = is_tag[s];
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            regs_reg <= '{default: '0};
            tag_reg  <= '{default: '0};
            busy_reg <= '0;
        end else if (bus.rdy_in) begin
            regs_reg <= regs_next;
            tag_reg  <= tag_next;
            busy_reg <= busy_next;
        end
    end
endmodule

// File: tb/tb_rf_rename_mp.sv
module tb_rf_rename_mp;
    logic clk_in = 1'b0;
    logic rst_in;

    always #5 clk_in = ~clk_in;

    rf_rename_mp_if #(.XLEN(32), .REG_W(5), .TAG_W(5), .ISSUE_W(2), .COMMIT_W(2)) bus ();

    rf_rename_mp #(.XLEN(32), .REG_W(5), .TAG_W(5), .ISSUE_W(2), .COMMIT_W(2)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    // Lookup numbering: 0 = slot0 rs1, 1 = slot0 rs2, 2 = slot1 rs1, 3 = slot1 rs2
    typedef struct packed {
        logic             rst;
        logic             rdy;
        logic             flush;
        logic [1:0]       cmv;
        logic [1:0][4:0]  cmrd;
        logic [1:0][31:0] cmval;
        logic [1:0][4:0]  cmtag;
        logic [1:0]       isv;
        logic [1:0][4:0]  isrd;
        logic [1:0][4:0]  istag;
        logic [1:0][4:0]  rs1;
        logic [1:0][4:0]  rs2;
        logic [4:0]       jr;
        logic [3:0]       ck;
        logic [3:0][31:0] ev;
        logic [3:0]       eb;
        logic [3:0][4:0]  et;
        logic             jck;
        logic [31:0]      jv;
        logic             jb;
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    function automatic vec_t nop();
        vec_t v;
        v = '0;
        v.rdy = 1'b1;
        return v;
    endfunction

    function automatic vec_t ex(vec_t vin, int l, logic b, logic [31:0] val, logic [4:0] t);
        vec_t v;
        v = vin;
        v.ck[l] = 1'b1;
        v.eb[l] = b;
        v.ev[l] = val;
        v.et[l] = t;
        return v;
    endfunction

    function automatic vec_t exj(vec_t vin, logic [31:0] val, logic b);
        vec_t v;
        v = vin;
        v.jck = 1'b1;
        v.jv  = val;
        v.jb  = b;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        rst_in       = v.rst;
        bus.rdy_in   = v.rdy;
        bus.flush_in = v.flush;
        bus.cm_valid = v.cmv;
        bus.cm_rd    = v.cmrd;
        bus.cm_value = v.cmval;
        bus.cm_tag   = v.cmtag;
        bus.is_valid = v.isv;
        bus.is_rd    = v.isrd;
        bus.is_tag   = v.istag;
        bus.rs1_idx  = v.rs1;
        bus.rs2_idx  = v.rs2;
        bus.jr_idx   = v.jr;
    endtask

    // Apply on the falling edge, compare 1 time unit later, state updates
    // on the following rising edge.
    task automatic run(vec_t v, string tname);
        logic [3:0][31:0] av;
        logic [3:0]       ab;
        logic [3:0][4:0]  at;
        int               e0;
        @(negedge clk_in);
        drive(v);
        #1;
        e0 = errors;
        av = {bus.rs2_value[63:32], bus.rs1_value[63:32], bus.rs2_value[31:0], bus.rs1_value[31:0]};
        ab = {bus.rs2_busy[1], bus.rs1_busy[1], bus.rs2_busy[0], bus.rs1_busy[0]};
        at = {bus.rs2_tag[9:5], bus.rs1_tag[9:5], bus.rs2_tag[4:0], bus.rs1_tag[4:0]};
        for (int l = 0; l < 4; l++) begin
            if (v.ck[l]) begin
                chk($sformatf("%s.L%0d.busy", tname, l), 32'(ab[l]), 32'(v.eb[l]));
                if (v.eb[l])
                    chk($sformatf("%s.L%0d.tag", tname, l), 32'(at[l]), 32'(v.et[l]));
                else
                    chk($sformatf("%s.L%0d.value", tname, l), av[l], v.ev[l]);
            end
        end
        if (v.jck) begin
            chk($sformatf("%s.jr_value", tname), bus.jr_value, v.jv);
            chk($sformatf("%s.jr_busy", tname), 32'(bus.jr_busy), 32'(v.jb));
        end
        $display("%s: rst=%0d rdy=%0d flush=%0d cmv=%b isv=%b -> %0d new errors",
                 tname, v.rst, v.rdy, v.flush, v.cmv, v.isv, errors - e0);
    endtask

    initial begin
        vec_t v;
        drive(nop());
        rst_in = 1'b1;

        // V0: reset, with a rename and a commit presented that must be ignored
        v = nop(); v.rst = 1; v.isv[0] = 1; v.isrd[0] = 5; v.istag[0] = 3;
        v.cmv[0] = 1; v.cmrd[0] = 5; v.cmval[0] = 32'h1234;
        vecs.push_back(v);
        // V1: x5 reads as ready zero after reset
        v = nop(); v.rs1[0] = 5; v.jr = 5;
        v = ex(v, 0, 0, 0, 0); v = exj(v, 0, 0);
        vecs.push_back(v);
        // V2: rename x3 tag 7; slot1 sees it, slot0 does not
        v = nop(); v.isv[0] = 1; v.isrd[0] = 3; v.istag[0] = 7; v.rs1[0] = 3; v.rs1[1] = 3;
        v = ex(v, 0, 0, 0, 0); v = ex(v, 2, 1, 0, 7);
        vecs.push_back(v);
        // V3: commit tag 7 value DEAD same cycle -> forwarded; jr not forwarded
        v = nop(); v.cmv[0] = 1; v.cmrd[0] = 3; v.cmtag[0] = 7; v.cmval[0] = 32'hDEAD;
        v.rs1[0] = 3; v.rs2[0] = 3; v.jr = 3;
        v = ex(v, 0, 0, 32'hDEAD, 0); v = ex(v, 1, 0, 32'hDEAD, 0); v = exj(v, 0, 1);
        vecs.push_back(v);
        // V4: committed
        v = nop(); v.rs1[0] = 3; v.jr = 3;
        v = ex(v, 0, 0, 32'hDEAD, 0); v = exj(v, 32'hDEAD, 0);
        vecs.push_back(v);
        // V5: both slots rename x4 (tags 2,5); slot1 rs2 sees slot0 tag only
        v = nop(); v.isv = 2'b11; v.isrd[0] = 4; v.istag[0] = 2; v.isrd[1] = 4; v.istag[1] = 5;
        v.rs2[1] = 4; v.rs2[0] = 4;
        v = ex(v, 3, 1, 0, 2); v = ex(v, 1, 0, 0, 0);
        vecs.push_back(v);
        // V6: higher slot won -> tag 5
        v = nop(); v.rs1[0] = 4; v.jr = 4;
        v = ex(v, 0, 1, 0, 5); v = exj(v, 0, 1);
        vecs.push_back(v);
        // V7: rename x6 tag 1
        v = nop(); v.isv[0] = 1; v.isrd[0] = 6; v.istag[0] = 1;
        vecs.push_back(v);
        // V8: re-rename x6 tag 9
        v = nop(); v.isv[0] = 1; v.isrd[0] = 6; v.istag[0] = 9; v.rs1[0] = 6; v.rs1[1] = 6;
        v = ex(v, 0, 1, 0, 1); v = ex(v, 2, 1, 0, 9);
        vecs.push_back(v);
        // V9: stale commit of x6 (tag 1) and real commit of x4 (tag 5)
        v = nop(); v.cmv = 2'b11;
        v.cmrd[0] = 6; v.cmtag[0] = 1; v.cmval[0] = 32'h11;
        v.cmrd[1] = 4; v.cmtag[1] = 5; v.cmval[1] = 32'h44;
        v.rs1[0] = 6; v.rs2[0] = 4;
        v = ex(v, 0, 1, 0, 9); v = ex(v, 1, 0, 32'h44, 0);
        vecs.push_back(v);
        // V10: x6 still busy tag 9 with value 0x11; x4 released
        v = nop(); v.rs1[0] = 6; v.rs2[0] = 4; v.jr = 6;
        v = ex(v, 0, 1, 0, 9); v = ex(v, 1, 0, 32'h44, 0); v = exj(v, 32'h11, 1);
        vecs.push_back(v);
        // V11: flush with commit x8 and rename x9; lookups ignore flush
        v = nop(); v.flush = 1; v.cmv[0] = 1; v.cmrd[0] = 8; v.cmval[0] = 32'h55;
        v.isv[0] = 1; v.isrd[0] = 9; v.istag[0] = 3; v.rs1[0] = 8; v.rs1[1] = 9;
        v = ex(v, 0, 0, 32'h55, 0); v = ex(v, 2, 1, 0, 3);
        vecs.push_back(v);
        // V12: everything idle after flush
        v = nop(); v.rs1[0] = 6; v.rs2[0] = 9; v.rs1[1] = 8; v.rs2[1] = 3; v.jr = 8;
        v = ex(v, 0, 0, 32'h11, 0); v = ex(v, 1, 0, 0, 0);
        v = ex(v, 2, 0, 32'h55, 0); v = ex(v, 3, 0, 32'hDEAD, 0); v = exj(v, 32'h55, 0);
        vecs.push_back(v);
        // V13: both ports commit x2; rename x0 seen as zero by slot1
        v = nop(); v.cmv = 2'b11; v.cmrd[0] = 2; v.cmval[0] = 32'hA; v.cmrd[1] = 2; v.cmval[1] = 32'hB;
        v.isv[0] = 1; v.isrd[0] = 0; v.istag[0] = 4; v.rs1[0] = 2; v.rs1[1] = 0;
        v = ex(v, 0, 0, 32'hB, 0); v = ex(v, 2, 0, 0, 0);
        vecs.push_back(v);
        // V14: x2 = 0xB; commit to x0 not forwarded
        v = nop(); v.cmv[0] = 1; v.cmrd[0] = 0; v.cmval[0] = 32'h77; v.rs1[0] = 2; v.rs2[0] = 0; v.jr = 0;
        v = ex(v, 0, 0, 32'hB, 0); v = ex(v, 1, 0, 0, 0); v = exj(v, 0, 0);
        vecs.push_back(v);
        // V15: rdy low; lookups still track inputs
        v = nop(); v.rdy = 0; v.isv[0] = 1; v.isrd[0] = 10; v.istag[0] = 6;
        v.cmv[0] = 1; v.cmrd[0] = 11; v.cmval[0] = 32'h99; v.rs1[1] = 10; v.rs1[0] = 11;
        v = ex(v, 2, 1, 0, 6); v = ex(v, 0, 0, 32'h99, 0);
        vecs.push_back(v);
        // V16: nothing changed during rdy low; x0 still zero
        v = nop(); v.rs1[0] = 11; v.rs2[0] = 10; v.rs1[1] = 0; v.jr = 0;
        v = ex(v, 0, 0, 0, 0); v = ex(v, 1, 0, 0, 0); v = ex(v, 2, 0, 0, 0); v = exj(v, 0, 0);
        vecs.push_back(v);

        for (int n = 0; n < vecs.size(); n++) begin
            run(vecs[n], $sformatf("vec%0d", n));
        end

        // Sequence A: rename pending, then reset wipes it even with a matching commit
        v = nop(); v.isv = 2'b11; v.isrd[0] = 12; v.istag[0] = 1; v.isrd[1] = 12; v.istag[1] = 13;
        run(v, "seqA.rename");
        v = nop(); v.rs1[0] = 12; v = ex(v, 0, 1, 0, 13);
        run(v, "seqA.busy");
        v = nop(); v.rst = 1; v.cmv[0] = 1; v.cmrd[0] = 12; v.cmtag[0] = 13; v.cmval[0] = 32'h5A;
        run(v, "seqA.reset");
        v = nop(); v.rs1[0] = 12; v.rs2[1] = 2; v.jr = 12;
        v = ex(v, 0, 0, 0, 0); v = ex(v, 3, 0, 0, 0); v = exj(v, 0, 0);
        run(v, "seqA.after");

        // Sequence B: rename beats a same-cycle commit clear on the same register
        v = nop(); v.isv[0] = 1; v.isrd[0] = 12; v.istag[0] = 3;
        run(v, "seqB.rename");
        v = nop(); v.cmv[0] = 1; v.cmrd[0] = 12; v.cmtag[0] = 3; v.cmval[0] = 32'h12;
        v.isv[0] = 1; v.isrd[0] = 12; v.istag[0] = 4;
        run(v, "seqB.both");
        v = nop(); v.rs1[0] = 12; v.jr = 12;
        v = ex(v, 0, 1, 0, 4); v = exj(v, 32'h12, 1);
        run(v, "seqB.after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
